// File: rtl/reg_alloc_tracker.sv
// Per-bank register-file occupancy tracker and lowest-free-entry allocator.
// Multiple invalidate ports per bank, optional same-cycle free reuse, sticky error flags.
module reg_alloc_tracker #(
    parameter int N_BANKS    = 32,
    parameter int BANK_DEPTH = 32,
    parameter int N_INV      = 2,
    parameter int BYPASS     = 1,
    parameter int ADDR_W     = $clog2(BANK_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pipe_en,
    input  logic [N_BANKS-1:0]                alloc_req,
    input  logic [N_BANKS*N_INV-1:0]          inv_vld,
    input  logic [N_BANKS*N_INV*ADDR_W-1:0]   inv_addr,
    output logic [N_BANKS*ADDR_W-1:0]         alloc_addr,
    output logic [N_BANKS-1:0]                alloc_ok,
    output logic [N_BANKS*(ADDR_W+1)-1:0]     occupancy,
    output logic [N_BANKS-1:0]                full,
    output logic [N_BANKS-1:0]                err_overflow,
    output logic [N_BANKS-1:0]                err_double_free,
    input  logic                              err_clr
);

    localparam int CNT_W = ADDR_W + 1;

    for (genvar i = 0; i < N_BANKS; i++) begin : g_bank
        logic [BANK_DEPTH-1:0] valid_q;
        logic [BANK_DEPTH-1:0] valid_d;
        logic [BANK_DEPTH-1:0] inv_hit;
        logic [BANK_DEPTH-1:0] allocatable;
        logic [CNT_W-1:0]      occ_q;
        logic [CNT_W-1:0]      occ_d;
        logic [ADDR_W-1:0]     addr;
        logic                  ok;
        logic                  commit;
        logic                  ov_new;
        logic                  df_new;
        logic                  full_q;
        logic                  ov_q;
        logic                  df_q;

        // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
        always_comb begin
            inv_hit = '0;
            df_new  = 1'b0;
            for (int p = 0; p < N_INV; p++) begin
                for (int j = 0; j < BANK_DEPTH; j++) begin
                    if (inv_vld[i*N_INV+p] &&
                        inv_addr[(i*N_INV+p)*ADDR_W +: ADDR_W] == ADDR_W'(j)) begin
                        inv_hit[j] = 1'b1;
                        if (!valid_q[j]) df_new = pipe_en;
                    end
                end
            end

            // Freed-this-cycle entries count as allocatable only in bypass mode.
            allocatable = ~valid_q | ((BYPASS != 0) ? inv_hit : '0);

            addr = '0;
            for (int j = BANK_DEPTH - 1; j >= 0; j--) begin
                if (allocatable[j]) addr = ADDR_W'(j);
            end
            ok = |allocatable;

            commit = pipe_en && alloc_req[i] && ok;
            ov_new = pipe_en && alloc_req[i] && !ok;

            // NOTE: blocking assignments here build next-state step by step; only always_ff uses <=.
            valid_d = valid_q;
            if (pipe_en) valid_d = valid_q & ~inv_hit;
            if (commit)  valid_d[addr] = 1'b1;

            occ_d = '0;
            for (int j = 0; j < BANK_DEPTH; j++) begin
                occ_d = occ_d + CNT_W'(valid_d[j]);
            end
        end

        // NOTE: the valid vector is reset explicitly; allocation depends on it starting empty.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= '0;
                occ_q   <= '0;
                full_q  <= 1'b0;
                ov_q    <= 1'b0;
                df_q    <= 1'b0;
            end else begin
                if (pipe_en) begin
                    valid_q <= valid_d;
                    occ_q   <= occ_d;
                    full_q  <= (occ_d == CNT_W'(BANK_DEPTH));
                end
                // A new error wins over a simultaneous clear.
                ov_q <= (ov_q & ~err_clr) | ov_new;
                df_q <= (df_q & ~err_clr) | df_new;
            end
        end

        assign alloc_addr[i*ADDR_W +: ADDR_W] = addr;
        assign alloc_ok[i]                    = ok;
        assign occupancy[i*CNT_W +: CNT_W]    = occ_q;
        assign full[i]                        = full_q;
        assign err_overflow[i]                = ov_q;
        assign err_double_free[i]             = df_q;

        a_addr_range : assert property (@(posedge clk) disable iff (rst)
            ({1'b0, addr} < CNT_W'(BANK_DEPTH)));
        a_occ_range : assert property (@(posedge clk) disable iff (rst)
            (occ_q <= CNT_W'(BANK_DEPTH)));
    end

endmodule

// File: doc/reg_alloc_tracker.md
Name: reg_alloc_tracker

Overview:
- Per-bank register-file occupancy tracker and free-entry allocator.
- Next generation of the single-invalidate valid-bit allocator. Adds multiple invalidate ports per bank, registered per-bank occupancy counters, and a full flag.
- Adds sticky overflow and double-free error flags, plus a parameter that selects same-cycle free-reuse (bypass).
- Sits beside the bank register files in the controller. Allocates write addresses for incoming results and releases entries on last read.

Parameters:
- N_BANKS, 32, number of register banks.
- BANK_DEPTH, 32, entries per bank; must be at least 2.
- N_INV, 2, invalidate ports per bank.
- BYPASS, 1, 1 = an entry freed this cycle may be allocated this cycle; 0 = only entries already free are allocatable.
- ADDR_W, $clog2(BANK_DEPTH), derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pipe_en  in  1  global stall. All state updates only when 1.
- alloc_req  in  N_BANKS  request one entry in bank i this cycle.
- inv_vld  in  N_BANKS*N_INV  invalidate strobe, per bank per port.
- inv_addr  in  N_BANKS*N_INV*ADDR_W  entry to invalidate, per bank per port.
- alloc_addr  out  N_BANKS*ADDR_W  lowest allocatable index per bank (combinational).
- alloc_ok  out  N_BANKS  an allocatable entry exists (combinational).
- occupancy  out  N_BANKS*(ADDR_W+1)  registered count of valid entries.
- full  out  N_BANKS  registered; 1 when occupancy == BANK_DEPTH.
- err_overflow  out  N_BANKS  sticky; alloc_req with alloc_ok=0 under pipe_en.
- err_double_free  out  N_BANKS  sticky; invalidate of a non-valid entry.
- err_clr  in  1  clears both sticky error vectors.

Behaviour:
- State per bank: valid[BANK_DEPTH], occupancy, error bits.
- Reset: on rst=1 at a clk edge, regardless of pipe_en:
  - all valid bits, occupancy, full and error flags go to 0.
  - Outputs after reset: alloc_addr=0, alloc_ok=1.
  - Reset mid-operation discards all in-flight requests of that cycle.
- Allocatable(j):
  - valid[j]==0, or
  - BYPASS==1 and some port p has inv_vld[i][p]=1 with inv_addr[i][p]==j.
- alloc_addr[i] = lowest j that is allocatable, else 0.
- alloc_ok[i] = OR over j of allocatable(j).
- Both are purely combinational from current state and current inputs. Zero latency, and valid even when pipe_en=0.
- Commit (pipe_en=1, alloc_req[i]=1, alloc_ok[i]=1): valid[alloc_addr[i]] is set to 1 at the next edge.
- Invalidate (pipe_en=1, inv_vld[i][p]=1): valid[inv_addr[i][p]] is cleared to 0 at the next edge, unless it equals a committed alloc_addr[i] that same cycle. Set wins over clear.
- Duplicate inv_addr on several ports in one cycle acts as a single clear. This is not an error.
- occupancy[i] next = popcount of next valid[i]. Equivalently: +1 for a commit, minus the number of distinct entries actually cleared from valid=1.
- full[i] next = (occupancy next == BANK_DEPTH).
- err_overflow[i] is set when pipe_en=1, alloc_req[i]=1 and alloc_ok[i]=0. No state change results.
- err_double_free[i] is set when pipe_en=1 and an inv port targets an entry with valid=0 at the start of the cycle.
  - Applies in both BYPASS modes.
  - An entry invalidated and allocated in the same cycle with valid=0 is still a double free.
- Error flags:
  - err_clr=1 clears all error bits at the next edge.
  - A new error in the same cycle sets its bit (set wins over clear).
  - err_clr acts regardless of pipe_en.
- pipe_en=0: valid, occupancy, full and errors (except err_clr) hold. Inputs are ignored.
- Full bank, BYPASS=1: a same-cycle invalidate makes alloc_ok=1, so a commit reuses the freed index and occupancy stays BANK_DEPTH.
- Full bank, BYPASS=0: alloc_ok=0.
- Banks are fully independent; no cross-bank interaction.
- Simulation assertions: alloc_addr[i] < BANK_DEPTH; occupancy[i] <= BANK_DEPTH.

Test Plan:
All scenarios use N_BANKS=2, BANK_DEPTH=4, N_INV=2.
- Reset then alloc_req=2'b01 for 4 cycles, pipe_en=1 → bank0 alloc_addr 0,1,2,3. Occupancy reaches 4, full[0]=1, alloc_ok[0]=0. Bank1 untouched (occupancy 0).
- Bank0 full, 5th alloc_req → err_overflow[0]=1 and holds. Occupancy stays 4. Then err_clr=1 → flag 0 the next cycle.
- Bank0 full, BYPASS=1, inv port0 addr 2 plus alloc_req same cycle → alloc_addr=2, valid[2] stays 1, occupancy 4, no error. With BYPASS=0 the same stimulus gives alloc_ok=0, err_overflow=1, occupancy 3.
- Valid={0,1,1,1} (entry0 free); ports 0 and 1 both invalidate addr 3 → single clear. Occupancy 3→2, next alloc_addr=0, no double-free.
- Invalidate addr 0 while valid[0]=0 → err_double_free[0]=1, occupancy unchanged.
- pipe_en=0 with alloc_req and inv_vld asserted for 3 cycles → no state change. alloc_addr still tracks inputs. rst asserted mid-stream → occupancy 0, all flags 0 next edge.
